pueo_command_scheduler: RTL
===========================

// Module: pueo_command_scheduler
// PURPOSE
//  Builds the 32-bit downlink command word, one per slot (SLOT_LEN sysclk cycles), which pueo_command_decoder on the SURF consumes.
//  Shares the word between five requesters: trigger times, run commands, mode1 specials, the cmdproc byte stream and the firmware byte stream.
//  Trigger field [15:0] and message field [31:16] are scheduled independently each slot.
// PARAMETERS
//  SLOT_LEN         8   sysclk cycles per command slot (>=4)
//  TRIG_FIFO_DEPTH  16  trigger FIFO entries (power of 2)
//  LIVE_EN          1   1: an idle slot sends a NOOP_LIVE message; 0: an idle slot sends no message
// PORTS
//  sysclk_i        in   1   system clock
//  rst_i           in   1   synchronous, active-high reset
//  trig_time_i     in   15  trigger time
//  trig_valid_i    in   1   trigger push request
//  trig_ready_o    out  1   trigger FIFO not full
//  run_cmd_i       in   2   00 NOOP_LIVE, 01 DO_SYNC, 10 RESET, 11 STOP
//  run_valid_i     in   1   run command pending
//  run_ready_o     out  1   run command consumed this cycle
//  spc_tdata_i     in   8   mode1 special code (01 reset, 02/03 fw mark A/B)
//  spc_tvalid_i / spc_tready_o        in/out  1   special handshake
//  cmd_tdata_i     in   8   cmdproc byte
//  cmd_tlast_i     in   1   last byte of the cmdproc packet
//  cmd_tvalid_i / cmd_tready_o        in/out  1   cmdproc handshake
//  fw_tdata_i      in   8   firmware byte
//  fw_tvalid_i / fw_tready_o          in/out  1   firmware handshake
//  command_o       out  32  command word
//  command_valid_o out  1   1-cycle strobe marking a new command_o
// BEHAVIOUR
//  Slot counter cnt runs 0..SLOT_LEN-1 and wraps. The LOAD cycle is cnt==SLOT_LEN-1.
//  - At LOAD, command_o is registered. command_valid_o=1 in the next cycle (cnt==0).
//  - command_o holds its value until the next LOAD.
//  Reset:
//  - cnt=0, FIFO empty, mode1 FSM=IDLE, RR pointer=cmd.
//  - command_o=32'h8000_0000, command_valid_o=0, all ready outputs=0 except trig_ready_o=1.
//  - The first strobe follows release by SLOT_LEN cycles.
//  Handshakes: run/spc/cmd/fw ready outputs are combinational. Each is high only in the LOAD cycle, and only for the granted requester whose valid is high. Transfer = valid&ready.
//  Trigger FIFO:
//  - Push when trig_valid_i & trig_ready_o. trig_ready_o=!full.
//  - At LOAD, if the FIFO is non-empty (state at start of cycle), pop: [15]=1, [14:0]=time. Otherwise [15:0]=0.
//  - A push in the LOAD cycle ships in the next slot. Push and pop in the same cycle keep the count unchanged.
//  - Data is never dropped: a full FIFO deasserts ready.
//  Message field:
//  - [31]=0 when a message is sent. [30:28]=0. [27:26]=runcmd. [25:24]=mode1type. [23:16]=mode1data.
//  - runcmd: run_cmd_i if run_valid_i (consumed), else 00.
//  - mode1type 00 special, 01 cmdproc byte, 11 cmdproc last byte or firmware byte, 10 none (data 00).
//  - No message: run idle, mode1 none and LIVE_EN=0 -> [31:16]=16'h8000. With LIVE_EN=1 this slot sends runcmd 00, type 10 instead.
//  Mode1 FSM:
//  - IDLE: grant priority is spc > round-robin(cmd, fw). The RR pointer flips after each cmd/fw grant.
//  - IDLE: granting cmd with tlast=0 -> PKT. With tlast=1 -> stay IDLE.
//  - PKT: only cmd is granted; spc and fw wait.
//  - PKT: cmd_tvalid_i low -> type 10, stay in PKT.
//  - PKT: granted byte with tlast=1 -> type 11, go to IDLE.
//  - Firmware bytes are single-byte transfers and never lock the FSM.
//  - Run commands and mode1 are independent: both can ship in one word.
//  rst_i mid-packet: FSM returns to IDLE, the FIFO is flushed, and nothing is half-sent. rst_i in the LOAD cycle suppresses that load.
// TESTING
//  1. Reset release, no requests, LIVE_EN=1 -> strobe at cycle 8, 16, ...; command_o=32'h0200_0000 (noop live, type 10).
//  2. Push triggers 0x1234, 0x0005 in one slot -> next two words have [15:0]=0x9234, then 0x8005; then [15:0]=0.
//  3. run_cmd=01 held with spc=0x02 -> one word 32'h0402_0000 (DO_SYNC + mark A); run_ready and spc_ready pulse once, in the LOAD cycle.
//  4. cmd packet AA,BB(last) while fw 11,22 pending -> words carry 01/AA, 11/BB, then fw 11/11, 11/22; fw waits while in PKT.
//  5. Fill 16 triggers -> trig_ready_o=0 on the 16th push; one pop re-asserts trig_ready_o next cycle; no entry is lost or reordered.
//  6. Assert rst_i while in PKT after byte AA -> next words send no cmdproc byte until a new packet; command_o=32'h8000_0000 right after reset.

Source files
------------

// File: rtl/pueo_command_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_command_scheduler
//  Description : Builds the 32-bit downlink command word once per slot. The
//                trigger field [15:0] drains a trigger-time FIFO; the message
//                field [31:16] merges run commands with the mode1 stream
//                (specials, cmdproc packets, firmware bytes).
//  Revision    : 1.0  initial release
// ============================================================================
module pueo_command_scheduler #(
    parameter int SLOT_LEN        = 8,
    parameter int TRIG_FIFO_DEPTH = 16,
    parameter int LIVE_EN         = 1
) (
    input  logic        sysclk_i,
    input  logic        rst_i,

    input  logic [14:0] trig_time_i,
    input  logic        trig_valid_i,
    output logic        trig_ready_o,

    input  logic [1:0]  run_cmd_i,
    input  logic        run_valid_i,
    output logic        run_ready_o,

    input  logic [7:0]  spc_tdata_i,
    input  logic        spc_tvalid_i,
    output logic        spc_tready_o,

    input  logic [7:0]  cmd_tdata_i,
    input  logic        cmd_tlast_i,
    input  logic        cmd_tvalid_i,
    output logic        cmd_tready_o,

    input  logic [7:0]  fw_tdata_i,
    input  logic        fw_tvalid_i,
    output logic        fw_tready_o,

    output logic [31:0] command_o,
    output logic        command_valid_o
);

    localparam int              CNT_W  = $clog2(SLOT_LEN);
    localparam int              PTR_W  = $clog2(TRIG_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(SLOT_LEN - 1);
    localparam logic [PTR_W:0]   C_FULL = (PTR_W + 1)'(TRIG_FIFO_DEPTH);

    localparam logic [1:0] C_M1_SPECIAL = 2'b00;
    localparam logic [1:0] C_M1_CMD     = 2'b01;
    localparam logic [1:0] C_M1_NONE    = 2'b10;
    localparam logic [1:0] C_M1_LAST    = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [14:0]      fifo_mem_q [TRIG_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    logic             rr_fw_q, rr_fw_d;
    logic [31:0]      command_q, command_d;
    logic             command_valid_q, command_valid_d;

    logic        load;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        gnt_spc;
    logic        gnt_cmd;
    logic        gnt_fw;
    logic [1:0]  runcmd;
    logic [1:0]  m1_type;
    logic [7:0]  m1_data;
    logic [15:0] msg_field;
    logic [15:0] trig_field;

    // Reset in the LOAD cycle cancels the load, so nothing is consumed then.
    always_comb begin
        load       = (cnt_q == C_LOAD) && !rst_i;
        fifo_full  = (count_q == C_FULL);
        fifo_empty = (count_q == '0);
        push       = trig_valid_i && !fifo_full;
        pop        = load && !fifo_empty;
    end

    // Mode1 arbitration: an open cmdproc packet locks out everyone else.
    always_comb begin
        gnt_spc = 1'b0;
        gnt_cmd = 1'b0;
        gnt_fw  = 1'b0;
        if (state_q == ST_PKT) begin
            gnt_cmd = cmd_tvalid_i;
        end else if (spc_tvalid_i) begin
            gnt_spc = 1'b1;
        end else if (!rr_fw_q) begin
            if (cmd_tvalid_i)     gnt_cmd = 1'b1;
            else if (fw_tvalid_i) gnt_fw  = 1'b1;
        end else begin
            if (fw_tvalid_i)       gnt_fw  = 1'b1;
            else if (cmd_tvalid_i) gnt_cmd = 1'b1;
        end
    end

    always_comb begin
        trig_ready_o = !fifo_full;
        run_ready_o  = load && run_valid_i;
        spc_tready_o = load && gnt_spc;
        cmd_tready_o = load && gnt_cmd;
        fw_tready_o  = load && gnt_fw;
    end

    always_comb begin
        runcmd  = run_valid_i ? run_cmd_i : 2'b00;
        m1_type = C_M1_NONE;
        m1_data = 8'h00;
        if (gnt_spc) begin
            m1_type = C_M1_SPECIAL;
            m1_data = spc_tdata_i;
        end else if (gnt_cmd) begin
            m1_type = cmd_tlast_i ? C_M1_LAST : C_M1_CMD;
            m1_data = cmd_tdata_i;
        end else if (gnt_fw) begin
            m1_type = C_M1_LAST;
            m1_data = fw_tdata_i;
        end

        if (!run_valid_i && (m1_type == C_M1_NONE) && (LIVE_EN == 0))
            msg_field = 16'h8000;
        else
            msg_field = {1'b0, 3'b000, runcmd, m1_type, m1_data};

        trig_field = fifo_empty ? 16'h0000 : {1'b1, fifo_mem_q[rd_ptr_q]};
    end

    always_comb begin
        cnt_d           = (cnt_q == C_LOAD) ? '0 : cnt_q + CNT_W'(1);
        command_d       = load ? {msg_field, trig_field} : command_q;
        command_valid_d = load;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        if (load && gnt_cmd) begin
            if (state_q == ST_IDLE && !cmd_tlast_i)
                state_d = ST_PKT;
            else if (state_q == ST_PKT && cmd_tlast_i)
                state_d = ST_IDLE;
        end
        rr_fw_d = rr_fw_q ^ (load && (gnt_cmd || gnt_fw));
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= ST_IDLE;
            rr_fw_q         <= 1'b0;
            command_q       <= 32'h8000_0000;
            command_valid_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            rr_fw_q         <= rr_fw_d;
            command_q       <= command_d;
            command_valid_q <= command_valid_d;
        end
    end

    // Storage needs no reset: the pointers alone define occupancy.
    always_ff @(posedge sysclk_i) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= trig_time_i;
    end

    assign command_o       = command_q;
    assign command_valid_o = command_valid_q;

endmodule
`default_nettype wire
